// File: rtl/ctrl_pkg.sv
// Shared encodings for the control-word pipeline: field positions, select
// encodings, RV32I opcodes and small decode helpers.
package ctrl_pkg;

    localparam int CW_W = 16;

    localparam int CW_REGWEN = 0;
    localparam int CW_IMMSEL = 1;
    localparam int CW_BRLUN  = 4;
    localparam int CW_ASEL   = 5;
    localparam int CW_BSEL   = 6;
    localparam int CW_ALUSEL = 7;
    localparam int CW_MEMRW  = 11;
    localparam int CW_WBSEL  = 12;
    localparam int CW_PCSEL  = 14;

    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_sel_e;
    typedef enum logic [1:0] {WB_MEM = 2'd0, WB_ALU, WB_PC4} wb_sel_e;
    typedef enum logic [1:0] {PC_SEQ = 2'd0, PC_JUMP, PC_BRANCH} pc_sel_e;
    typedef enum logic [1:0] {FWD_REG = 2'd0, FWD_X, FWD_WB} fwd_sel_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [CW_W-1:0] CW_NOP = '0;

    // ASel = 1 routes rs1 to the ALU A input, 0 routes the PC.
    function automatic logic [CW_W-1:0] pack_cw(
        input logic     reg_wen,
        input imm_sel_e imm_sel,
        input logic     br_lun,
        input logic     a_sel,
        input logic     b_sel,
        input alu_sel_e alu_sel,
        input logic     mem_rw,
        input wb_sel_e  wb_sel,
        input pc_sel_e  pc_sel
    );
        logic [CW_W-1:0] cw;
        cw                   = CW_NOP;
        cw[CW_REGWEN]        = reg_wen;
        cw[CW_IMMSEL +: 3]   = imm_sel;
        cw[CW_BRLUN]         = br_lun;
        cw[CW_ASEL]          = a_sel;
        cw[CW_BSEL]          = b_sel;
        cw[CW_ALUSEL +: 4]   = alu_sel;
        cw[CW_MEMRW]         = mem_rw;
        cw[CW_WBSEL +: 2]    = wb_sel;
        cw[CW_PCSEL +: 2]    = pc_sel;
        return cw;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_OP) || (opcode == OP_OPIMM) || (opcode == OP_LOAD) ||
               (opcode == OP_JALR) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder: opcode/funct fields to a 16-bit control word.
// FENCE and SYSTEM opcodes are not supported and decode as illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            inst_valid,
    output logic [CW_W-1:0] cw,
    output logic            illegal
);

    logic     legal;
    logic     reg_wen;
    logic     br_lun;
    logic     a_sel;
    logic     b_sel;
    logic     mem_rw;
    imm_sel_e imm_sel;
    alu_sel_e alu_sel;
    alu_sel_e alu_f3;
    wb_sel_e  wb_sel;
    pc_sel_e  pc_sel;

    // Base ALU op chosen by funct3 for register and immediate arithmetic.
    always_comb begin
        alu_f3 = ALU_ADD;
        case (funct3)
            3'd0:    alu_f3 = ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        legal   = 1'b0;
        reg_wen = 1'b0;
        br_lun  = 1'b0;
        a_sel   = 1'b0;
        b_sel   = 1'b0;
        mem_rw  = 1'b0;
        imm_sel = IMM_I;
        alu_sel = ALU_ADD;
        wb_sel  = WB_MEM;
        pc_sel  = PC_SEQ;
        case (opcode)
            OP_LUI: begin
                legal = 1'b1; reg_wen = 1'b1; imm_sel = IMM_U; b_sel = 1'b1;
                alu_sel = ALU_PASSB; wb_sel = WB_ALU;
            end
            OP_AUIPC: begin
                legal = 1'b1; reg_wen = 1'b1; imm_sel = IMM_U; b_sel = 1'b1;
                wb_sel = WB_ALU;
            end
            OP_JAL: begin
                legal = 1'b1; reg_wen = 1'b1; imm_sel = IMM_J; b_sel = 1'b1;
                wb_sel = WB_PC4; pc_sel = PC_JUMP;
            end
            OP_JALR: begin
                legal = (funct3 == 3'd0); reg_wen = 1'b1; a_sel = 1'b1; b_sel = 1'b1;
                wb_sel = WB_PC4; pc_sel = PC_JUMP;
            end
            OP_BRANCH: begin
                legal = (funct3 != 3'd2) && (funct3 != 3'd3);
                imm_sel = IMM_B; b_sel = 1'b1; pc_sel = PC_BRANCH;
                br_lun = funct3[2] & funct3[1];
            end
            OP_LOAD: begin
                legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
                reg_wen = 1'b1; a_sel = 1'b1; b_sel = 1'b1; wb_sel = WB_MEM;
            end
            OP_STORE: begin
                legal = (funct3 <= 3'd2); imm_sel = IMM_S; a_sel = 1'b1; b_sel = 1'b1;
                mem_rw = 1'b1;
            end
            OP_OPIMM: begin
                reg_wen = 1'b1; a_sel = 1'b1; b_sel = 1'b1; wb_sel = WB_ALU;
                alu_sel = alu_f3;
                legal   = 1'b1;
                if (funct3 == 3'd1) begin
                    legal = (funct7 == 7'h00);
                end else if (funct3 == 3'd5) begin
                    legal   = (funct7 == 7'h00) || (funct7 == 7'h20);
                    alu_sel = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                end
            end
            OP_OP: begin
                reg_wen = 1'b1; a_sel = 1'b1; wb_sel = WB_ALU;
                if (funct7 == 7'h00) begin
                    legal = 1'b1; alu_sel = alu_f3;
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    legal = 1'b1; alu_sel = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    legal = 1'b1; alu_sel = ALU_SRA;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign cw      = (inst_valid && legal)
                   ? pack_cw(reg_wen, imm_sel, br_lun, a_sel, b_sel, alu_sel, mem_rw, wb_sel, pc_sel)
                   : CW_NOP;
    assign illegal = inst_valid & ~legal;

endmodule

// File: rtl/ctrl_word_pipe.sv
// Pipelined control unit: decodes D, carries control words through the
// X/M/W stages, and resolves load-use stalls, redirects and forwarding.
module ctrl_word_pipe
    import ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CW_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    inst_in,
    input  logic                           inst_valid,
    input  logic                           br_taken,
    input  logic                           flush_ext,
    output logic [NUM_STAGES*CW_WIDTH-1:0] stage_cw,
    output logic [NUM_STAGES-1:0]          stage_valid,
    output logic [NUM_STAGES*5-1:0]        stage_rd,
    output logic                           stall_d,
    output logic                           pc_redirect,
    output logic [1:0]                     fwd_a,
    output logic [1:0]                     fwd_b,
    output logic                           illegal
);

    logic [CW_WIDTH-1:0] cw_q    [NUM_STAGES];
    logic [CW_WIDTH-1:0] cw_d    [NUM_STAGES];
    logic [4:0]          rd_q    [NUM_STAGES];
    logic [4:0]          rd_d    [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;

    logic [6:0]          opcode;
    logic [4:0]          rs1_d;
    logic [4:0]          rs2_d;
    logic [4:0]          rdf_d;
    logic [CW_W-1:0]     cw_dec;
    logic                illegal_dec;
    logic                redirect_raw;
    logic                load_use;
    logic                fwd_x_ok;
    logic                fwd_wb_ok;

    assign opcode = inst_in[6:0];
    assign rdf_d  = inst_in[11:7];
    assign rs1_d  = inst_in[19:15];
    assign rs2_d  = inst_in[24:20];

    ctrl_decode u_decode (
        .opcode     (opcode),
        .funct3     (inst_in[14:12]),
        .funct7     (inst_in[31:25]),
        .inst_valid (inst_valid),
        .cw         (cw_dec),
        .illegal    (illegal_dec)
    );

    assign illegal = illegal_dec;

    // Hazard and forwarding decisions, all taken from stage 0/1 contents.
    always_comb begin
        redirect_raw = valid_q[0] &&
                       ((cw_q[0][CW_PCSEL +: 2] == PC_JUMP) ||
                        ((cw_q[0][CW_PCSEL +: 2] == PC_BRANCH) && br_taken));
        load_use     = valid_q[0] && inst_valid && cw_q[0][CW_REGWEN] &&
                       (cw_q[0][CW_WBSEL +: 2] == WB_MEM) && (rd_q[0] != 5'd0) &&
                       ((uses_rs1(opcode) && (rs1_d == rd_q[0])) ||
                        (uses_rs2(opcode) && (rs2_d == rd_q[0])));
        fwd_x_ok     = valid_q[0] && cw_q[0][CW_REGWEN] && (rd_q[0] != 5'd0) &&
                       (cw_q[0][CW_WBSEL +: 2] != WB_MEM);
        fwd_wb_ok    = valid_q[1] && cw_q[1][CW_REGWEN] && (rd_q[1] != 5'd0);

        pc_redirect = redirect_raw & ~rst;
        stall_d     = load_use & ~redirect_raw & ~rst;

        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (!rst) begin
            if (fwd_x_ok && rd_q[0] == rs1_d)       fwd_a = FWD_X;
            else if (fwd_wb_ok && rd_q[1] == rs1_d) fwd_a = FWD_WB;
            if (fwd_x_ok && rd_q[0] == rs2_d)       fwd_b = FWD_X;
            else if (fwd_wb_ok && rd_q[1] == rs2_d) fwd_b = FWD_WB;
        end
    end

    always_comb begin
        if (flush_ext || redirect_raw || load_use) begin
            cw_d[0]    = '0;
            valid_d[0] = 1'b0;
            rd_d[0]    = 5'd0;
        end else begin
            cw_d[0]    = cw_dec;
            valid_d[0] = inst_valid & ~illegal_dec;
            rd_d[0]    = (inst_valid & ~illegal_dec) ? rdf_d : 5'd0;
        end
        for (int s = 1; s < NUM_STAGES; s++) begin
            cw_d[s]    = cw_q[s-1];
            valid_d[s] = valid_q[s-1];
            rd_d[s]    = rd_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                cw_q[s] <= '0;
                rd_q[s] <= 5'd0;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < NUM_STAGES; s++) begin
                cw_q[s] <= cw_d[s];
                rd_q[s] <= rd_d[s];
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign stage_cw[g*CW_WIDTH +: CW_WIDTH] = cw_q[g];
        assign stage_rd[g*5 +: 5]               = rd_q[g];
    end
    assign stage_valid = valid_q;

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// Self-checking bench for ctrl_word_pipe: decode vector table, directed
// hazard sequences, then randomized traffic against a behavioural model.
module tb_ctrl_word_pipe;

    localparam int NS = 3;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     inst_in;
    logic            inst_valid;
    logic            br_taken;
    logic            flush_ext;
    logic [NS*CW-1:0] stage_cw;
    logic [NS-1:0]   stage_valid;
    logic [NS*5-1:0] stage_rd;
    logic            stall_d;
    logic            pc_redirect;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            illegal;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ctrl_word_pipe #(.NUM_STAGES(NS), .CW_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_in     (inst_in),
        .inst_valid  (inst_valid),
        .br_taken    (br_taken),
        .flush_ext   (flush_ext),
        .stage_cw    (stage_cw),
        .stage_valid (stage_valid),
        .stage_rd    (stage_rd),
        .stall_d     (stall_d),
        .pc_redirect (pc_redirect),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .illegal     (illegal)
    );

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic [15:0] exp_cw;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[15];

    // Behavioural model state: one entry per stage.
    logic [15:0] m_cw[NS];
    logic        m_valid[NS];
    logic [4:0]  m_rd[NS];
    int          alu_by_f3[8] = '{0, 5, 8, 9, 4, 6, 3, 2};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic v, input logic br,
                                 input logic fl, input logic r);
        inst_in    = inst;
        inst_valid = v;
        br_taken   = br;
        flush_ext  = fl;
        rst        = r;
    endtask

    task automatic doReset();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference decode from the RV32I instruction tables.
    function automatic void refDecode(input logic [31:0] inst, input logic v,
                                      output logic [15:0] cw, output logic ill);
        int regwen = 0, imm = 0, brlun = 0, asel = 0, bsel = 0, alu = 0, memrw = 0, wb = 0, pc = 0;
        bit ok = 0;
        int f3 = int'(inst[14:12]);
        int f7 = int'(inst[31:25]);
        case (inst[6:0])
            7'h37: begin ok = 1; regwen = 1; imm = 3; bsel = 1; alu = 10; wb = 1; end
            7'h17: begin ok = 1; regwen = 1; imm = 3; bsel = 1; wb = 1; end
            7'h6F: begin ok = 1; regwen = 1; imm = 4; bsel = 1; wb = 2; pc = 1; end
            7'h67: begin ok = (f3 == 0); regwen = 1; asel = 1; bsel = 1; wb = 2; pc = 1; end
            7'h63: begin ok = (f3 != 2 && f3 != 3); imm = 2; bsel = 1; pc = 2; brlun = (f3 >= 6); end
            7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                         regwen = 1; asel = 1; bsel = 1; wb = 0; end
            7'h23: begin ok = (f3 <= 2); imm = 1; asel = 1; bsel = 1; memrw = 1; end
            7'h13: begin
                regwen = 1; asel = 1; bsel = 1; wb = 1; alu = alu_by_f3[f3]; ok = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin ok = (f7 == 0 || f7 == 'h20); if (f7 == 'h20) alu = 7; end
            end
            7'h33: begin
                regwen = 1; asel = 1; wb = 1;
                if (f7 == 0) begin ok = 1; alu = alu_by_f3[f3]; end
                else if (f7 == 'h20 && f3 == 0) begin ok = 1; alu = 1; end
                else if (f7 == 'h20 && f3 == 5) begin ok = 1; alu = 7; end
            end
            default: ok = 0;
        endcase
        cw  = (v && ok) ? 16'(regwen + imm*2 + brlun*16 + asel*32 + bsel*64 + alu*128 +
                              memrw*2048 + wb*4096 + pc*16384) : 16'h0;
        ill = v && !ok;
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] rs);
        if (m_valid[0] && m_cw[0][0] && m_rd[0] != 0 && m_rd[0] == rs && m_cw[0][13:12] != 0)
            return 2'd1;
        if (m_valid[1] && m_cw[1][0] && m_rd[1] != 0 && m_rd[1] == rs)
            return 2'd2;
        return 2'd0;
    endfunction

    // Compare all outputs against the model, then advance the model one clock.
    task automatic modelCycle(output logic exp_stall);
        logic [15:0] dcw;
        logic        dill, redir, load, u1, u2, take;
        logic [6:0]  op;
        refDecode(inst_in, inst_valid, dcw, dill);
        op    = inst_in[6:0];
        u1    = (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h23 || op == 7'h63);
        u2    = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        redir = m_valid[0] && (m_cw[0][15:14] == 1 || (m_cw[0][15:14] == 2 && br_taken));
        load  = m_valid[0] && m_cw[0][0] && m_cw[0][13:12] == 0 && m_rd[0] != 0 && inst_valid &&
                ((u1 && inst_in[19:15] == m_rd[0]) || (u2 && inst_in[24:20] == m_rd[0]));
        exp_stall = load && !redir && !rst;
        checkOutput("stall_d", 32'(stall_d), 32'(exp_stall));
        checkOutput("pc_redirect", 32'(pc_redirect), 32'(redir && !rst));
        checkOutput("fwd_a", 32'(fwd_a), rst ? 32'd0 : 32'(refFwd(inst_in[19:15])));
        checkOutput("fwd_b", 32'(fwd_b), rst ? 32'd0 : 32'(refFwd(inst_in[24:20])));
        checkOutput("illegal", 32'(illegal), 32'(dill));
        for (int s = 0; s < NS; s++) begin
            checkOutput($sformatf("stage_cw[%0d]", s), 32'(stage_cw[s*CW +: CW]), 32'(m_cw[s]));
            checkOutput($sformatf("stage_valid[%0d]", s), 32'(stage_valid[s]), 32'(m_valid[s]));
            checkOutput($sformatf("stage_rd[%0d]", s), 32'(stage_rd[s*5 +: 5]), 32'(m_rd[s]));
        end
        if (rst) begin
            for (int s = 0; s < NS; s++) begin m_cw[s] = 0; m_valid[s] = 0; m_rd[s] = 0; end
        end else begin
            for (int s = NS - 1; s > 0; s--) begin
                m_cw[s] = m_cw[s-1]; m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1];
            end
            take       = !(flush_ext || redir || load) && inst_valid && !dill;
            m_cw[0]    = (flush_ext || redir || load) ? 16'h0 : dcw;
            m_valid[0] = take;
            m_rd[0]    = take ? inst_in[11:7] : 5'd0;
        end
    endtask

    function automatic logic [31:0] randInst();
        logic [4:0]  rd  = 5'($urandom_range(0, 3));
        logic [4:0]  rs1 = 5'($urandom_range(0, 3));
        logic [4:0]  rs2 = 5'($urandom_range(0, 3));
        logic [2:0]  f3  = 3'($urandom_range(0, 7));
        logic [6:0]  f7  = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        logic [11:0] imm = 12'($urandom);
        case ($urandom_range(0, 11))
            0:       return {f7, rs2, rs1, f3, rd, 7'h33};
            1:       return {f7, imm[4:0], rs1, f3, rd, 7'h13};
            2, 10:   return {imm, rs1, 3'd2, rd, 7'h03};
            3:       return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            4:       return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h63};
            5:       return {imm, rs1[2:0], 5'd0, rd, 7'h37};
            6:       return {imm, rs1[2:0], 5'd0, rd, 7'h17};
            7:       return {imm, rs1[2:0], 5'd0, rd, 7'h6F};
            8:       return {imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67};
            11:      return {imm, rs1, 3'd0, rd, 7'h13};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic s;
        logic [31:0] cur;

        vecs[0]  = '{32'h00500093, 1'b1, 16'h1061, 1'b0};
        vecs[1]  = '{32'h002101B3, 1'b1, 16'h1021, 1'b0};
        vecs[2]  = '{32'h402082B3, 1'b1, 16'h10A1, 1'b0};
        vecs[3]  = '{32'h0000A103, 1'b1, 16'h0061, 1'b0};
        vecs[4]  = '{32'h0020A223, 1'b1, 16'h0862, 1'b0};
        vecs[5]  = '{32'h00208463, 1'b1, 16'h8044, 1'b0};
        vecs[6]  = '{32'h0020E463, 1'b1, 16'h8054, 1'b0};
        vecs[7]  = '{32'h123452B7, 1'b1, 16'h1547, 1'b0};
        vecs[8]  = '{32'h010000EF, 1'b1, 16'h6049, 1'b0};
        vecs[9]  = '{32'h4030D313, 1'b1, 16'h13E1, 1'b0};
        vecs[10] = '{32'h0000007F, 1'b1, 16'h0000, 1'b1};
        vecs[11] = '{32'h00500093, 1'b0, 16'h0000, 1'b0};
        vecs[12] = '{32'h40001093, 1'b1, 16'h0000, 1'b1};
        vecs[13] = '{32'h00001217, 1'b1, 16'h1047, 1'b0};
        vecs[14] = '{32'h000100E7, 1'b1, 16'h6061, 1'b0};

        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("reset stage_valid", 32'(stage_valid), 32'd0);
        checkOutput("reset stage_cw", 32'(stage_cw[31:0]), 32'd0);
        checkOutput("reset stage_rd", 32'(stage_rd), 32'd0);
        checkOutput("reset stall_d", 32'(stall_d), 32'd0);

        for (int i = 0; i < 15; i++) begin
            doReset();
            applyStimulus(vecs[i].inst, vecs[i].valid, 1'b0, 1'b0, 1'b0);
            #1 checkOutput($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vecs[i].exp_ill));
            @(negedge clk);
            applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d cw", i), 32'(stage_cw[15:0]), 32'(vecs[i].exp_cw));
            checkOutput($sformatf("vec%0d valid", i), 32'(stage_valid[0]),
                        32'(vecs[i].valid & ~vecs[i].exp_ill));
        end

        // addi travels from stage 0 to stage 2
        doReset();
        applyStimulus(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("addi rd0", 32'(stage_rd[4:0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("addi cw2", 32'(stage_cw[47:32]), 32'h1061);
        checkOutput("addi valid2", 32'(stage_valid[2]), 32'd1);

        // load-use: lw x2 then add x3,x2,x2
        doReset();
        applyStimulus(32'h0000A103, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h002101B3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("lu stall", 32'(stall_d), 32'd1);
        @(negedge clk);
        #1 checkOutput("lu bubble", 32'(stage_valid[1:0]), 32'b10);
        checkOutput("lu stall2", 32'(stall_d), 32'd0);
        checkOutput("lu fwd_a", 32'(fwd_a), 32'd2);
        checkOutput("lu fwd_b", 32'(fwd_b), 32'd2);
        @(negedge clk);
        checkOutput("lu add cw0", 32'(stage_cw[15:0]), 32'h1021);
        checkOutput("lu add rd0", 32'(stage_rd[4:0]), 32'd3);

        // taken beq kills D while older stages keep advancing
        doReset();
        applyStimulus(32'h0000A103, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h00108463, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h002101B3, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("br redirect", 32'(pc_redirect), 32'd1);
        @(negedge clk);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("br bubble", 32'(stage_valid[0]), 32'd0);
        checkOutput("br cw1", 32'(stage_cw[31:16]), 32'h8044);
        checkOutput("br cw2", 32'(stage_cw[47:32]), 32'h0061);

        // stage-0 forwarding, and none from an x0 producer
        doReset();
        applyStimulus(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h001082B3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("fx fwd_a", 32'(fwd_a), 32'd1);
        checkOutput("fx fwd_b", 32'(fwd_b), 32'd1);
        doReset();
        applyStimulus(32'h00500013, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h000002B3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("x0 fwd_a", 32'(fwd_a), 32'd0);
        checkOutput("x0 fwd_b", 32'(fwd_b), 32'd0);

        // reset while a stall, then a redirect, is pending
        doReset();
        applyStimulus(32'h0000A103, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h002101B3, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("rst stall", 32'(stall_d), 32'd0);
        @(negedge clk);
        checkOutput("rst valid", 32'(stage_valid), 32'd0);
        applyStimulus(32'h010000EF, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(32'h002101B3, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("rst redirect", 32'(pc_redirect), 32'd0);
        @(negedge clk);
        checkOutput("rst valid2", 32'(stage_valid), 32'd0);

        // randomized traffic against the model
        doReset();
        for (int s2 = 0; s2 < NS; s2++) begin m_cw[s2] = 0; m_valid[s2] = 0; m_rd[s2] = 0; end
        s   = 1'b0;
        cur = randInst();
        for (int c = 0; c < 400; c++) begin
            if (!s) cur = randInst();
            applyStimulus(cur, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
            #1 modelCycle(s);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
